// File: rtl/msx_bus_slave_arbiter_if.sv
// Signal bundle between the filtered MSX cartridge bus, the cycle arbiter and
// its internal slave ports.
interface msx_bus_slave_arbiter_if #(
  parameter int NUM_SLAVES = 4
);
  // Bus side (registered cartridge signals)
  logic [15:0]             ADDR;
  logic [7:0]              DIN;
  logic                    SLTSL_n;
  logic                    MERQ_n;
  logic                    IORQ_n;
  logic                    RD_n;
  logic                    WR_n;
  logic                    RFSH_n;
  logic [7:0]              DOUT;
  logic                    BUSDIR_n;
  logic                    WAIT_n;

  // Slave side. slv_rd_stb / slv_wr_stb are one-cycle request pulses to the
  // slave in slv_grant; that slave completes the access by raising slv_ready,
  // which counts from the strobe cycle on and only until the first completion.
  logic [NUM_SLAVES-1:0]   slv_hit;
  logic [8*NUM_SLAVES-1:0] slv_rdata;
  logic [NUM_SLAVES-1:0]   slv_ready;
  logic [NUM_SLAVES-1:0]   slv_grant;
  logic                    slv_rd_stb;
  logic                    slv_wr_stb;
  logic [15:0]             slv_addr;
  logic [7:0]              slv_wdata;
  logic                    slv_io;
  logic                    timeout_err;
  logic [2:0]              dbg_state;

  modport slave (
    input  ADDR, DIN, SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n, RFSH_n,
    input  slv_hit, slv_rdata, slv_ready,
    output slv_grant, slv_rd_stb, slv_wr_stb, slv_addr, slv_wdata, slv_io,
    output DOUT, BUSDIR_n, WAIT_n, timeout_err, dbg_state
  );

  modport master (
    output ADDR, DIN, SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n, RFSH_n,
    output slv_hit, slv_rdata, slv_ready,
    input  slv_grant, slv_rd_stb, slv_wr_stb, slv_addr, slv_wdata, slv_io,
    input  DOUT, BUSDIR_n, WAIT_n, timeout_err, dbg_state
  );
endinterface

// File: rtl/msx_bus_slave_arbiter.sv
// MSX bus-cycle controller: qualifies memory/IO cycles, grants them to one
// internal slave, and sequences WAIT_n and data-bus ownership.
module msx_bus_slave_arbiter #(
  parameter int NUM_SLAVES    = 4,
  parameter int STABLE_CYCLES = 2,
  parameter int WAIT_TIMEOUT  = 255
) (
  input logic                    CLK,
  input logic                    RESET_n,
  msx_bus_slave_arbiter_if.slave bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARB     = 3'd1,
    ACCESS  = 3'd2,
    DRIVE   = 3'd3,
    RELEASE = 3'd4
  } state_t;

  localparam logic [3:0]  STAB_LAST = 4'(STABLE_CYCLES - 1);
  localparam logic [15:0] TMO_LAST  = 16'(WAIT_TIMEOUT - 1);

  state_t                state_q, state_d;
  logic [3:0]            stab_q, stab_d;
  logic [15:0]           tmo_q, tmo_d;
  logic                  rd_q, rd_d;
  logic [NUM_SLAVES-1:0] grant_q, grant_d;
  logic                  rd_stb_q, rd_stb_d;
  logic                  wr_stb_q, wr_stb_d;
  logic [15:0]           addr_q, addr_d;
  logic [7:0]            wdata_q, wdata_d;
  logic                  io_q, io_d;
  logic [7:0]            dout_q, dout_d;
  logic                  busdir_n_q, busdir_n_d;
  logic                  wait_n_q, wait_n_d;
  logic                  tmo_err_q, tmo_err_d;

  logic                  xfer, mem_cyc, io_cyc, start, ready;
  logic [NUM_SLAVES-1:0] first_hit;
  logic [7:0]            rdata;

  // Exactly one of RD_n/WR_n low; overlapping MERQ_n/IORQ_n never qualifies.
  assign xfer    = !bus.RD_n ^ !bus.WR_n;
  assign mem_cyc = !bus.SLTSL_n & !bus.MERQ_n & bus.IORQ_n & bus.RFSH_n & xfer;
  assign io_cyc  = !bus.IORQ_n & bus.MERQ_n & xfer;
  assign start   = mem_cyc | io_cyc;
  assign ready   = |(bus.slv_ready & grant_q);

  always_comb begin
    first_hit = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
      if (bus.slv_hit[i]) begin
        first_hit    = '0;
        first_hit[i] = 1'b1;
      end
    end
  end

  always_comb begin
    rdata = 8'h00;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (grant_q[i]) rdata = rdata | bus.slv_rdata[8*i +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    stab_d     = stab_q;
    tmo_d      = tmo_q;
    rd_d       = rd_q;
    grant_d    = grant_q;
    rd_stb_d   = 1'b0;
    wr_stb_d   = 1'b0;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    io_d       = io_q;
    dout_d     = dout_q;
    busdir_n_d = busdir_n_q;
    wait_n_d   = wait_n_q;
    tmo_err_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!start) begin
          stab_d = 4'd0;
        end else if (stab_q == STAB_LAST) begin
          stab_d  = 4'd0;
          state_d = ARB;
          addr_d  = bus.ADDR;
          wdata_d = bus.DIN;
          io_d    = io_cyc;
          rd_d    = !bus.RD_n;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end
      ARB: begin
        grant_d = first_hit;
        if (|bus.slv_hit) begin
          state_d  = ACCESS;
          rd_stb_d = rd_q;
          wr_stb_d = !rd_q;
          wait_n_d = 1'b0;
          tmo_d    = 16'd0;
        end else begin
          state_d = RELEASE;
        end
      end
      ACCESS: begin
        tmo_d = tmo_q + 16'd1;
        // A read that times out still owns the bus and returns 8'hFF.
        if (ready || tmo_q == TMO_LAST) begin
          tmo_err_d = !ready;
          wait_n_d  = 1'b1;
          tmo_d     = 16'd0;
          if (rd_q) begin
            dout_d     = ready ? rdata : 8'hFF;
            busdir_n_d = 1'b0;
            state_d    = DRIVE;
          end else begin
            state_d = RELEASE;
          end
        end
      end
      DRIVE: begin
        if (!bus.RD_n) begin
          stab_d = 4'd0;
        end else if (stab_q == STAB_LAST) begin
          stab_d     = 4'd0;
          busdir_n_d = 1'b1;
          dout_d     = 8'hFF;
          grant_d    = '0;
          state_d    = IDLE;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end
      RELEASE: begin
        if (!(bus.RD_n && bus.WR_n)) begin
          stab_d = 4'd0;
        end else if (stab_q == STAB_LAST) begin
          stab_d  = 4'd0;
          grant_d = '0;
          state_d = IDLE;
        end else begin
          stab_d = stab_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state_q    <= IDLE;
      stab_q     <= 4'd0;
      tmo_q      <= 16'd0;
      rd_q       <= 1'b0;
      grant_q    <= '0;
      rd_stb_q   <= 1'b0;
      wr_stb_q   <= 1'b0;
      addr_q     <= 16'h0000;
      wdata_q    <= 8'h00;
      io_q       <= 1'b0;
      dout_q     <= 8'hFF;
      busdir_n_q <= 1'b1;
      wait_n_q   <= 1'b1;
      tmo_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      stab_q     <= stab_d;
      tmo_q      <= tmo_d;
      rd_q       <= rd_d;
      grant_q    <= grant_d;
      rd_stb_q   <= rd_stb_d;
      wr_stb_q   <= wr_stb_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      io_q       <= io_d;
      dout_q     <= dout_d;
      busdir_n_q <= busdir_n_d;
      wait_n_q   <= wait_n_d;
      tmo_err_q  <= tmo_err_d;
    end
  end

  assign bus.slv_grant   = grant_q;
  assign bus.slv_rd_stb  = rd_stb_q;
  assign bus.slv_wr_stb  = wr_stb_q;
  assign bus.slv_addr    = addr_q;
  assign bus.slv_wdata   = wdata_q;
  assign bus.slv_io      = io_q;
  assign bus.DOUT        = dout_q;
  assign bus.BUSDIR_n    = busdir_n_q;
  assign bus.WAIT_n      = wait_n_q;
  assign bus.timeout_err = tmo_err_q;
  assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_msx_bus_slave_arbiter.sv
// Bench for msx_bus_slave_arbiter: directed plan cases plus randomized cycles
// checked against a transaction-level model of the expected bus behaviour.
module tb_msx_bus_slave_arbiter;
  localparam int NS    = 4;
  localparam int STAB  = 2;
  localparam int TMO   = 8;
  localparam int NEVER = 1000;

  logic CLK = 1'b0;
  logic RESET_n = 1'b0;
  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_q[$];

  msx_bus_slave_arbiter_if #(.NUM_SLAVES(NS)) bus ();

  msx_bus_slave_arbiter #(
    .NUM_SLAVES(NS), .STABLE_CYCLES(STAB), .WAIT_TIMEOUT(TMO)
  ) dut (
    .CLK(CLK), .RESET_n(RESET_n), .bus(bus)
  );

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_q(input string tag, input logic [31:0] obs);
    logic [31:0] e;
    e = (exp_q.size() == 0) ? 32'hDEADBEEF : exp_q.pop_front();
    chk(tag, obs, e);
  endtask

  // ---------------- reference model ----------------
  function automatic int lowest_idx(input logic [NS-1:0] hit);
    for (int i = 0; i < NS; i++) if (hit[i]) return i;
    return -1;
  endfunction

  // Expected outcome of one bus cycle, in the order run_txn compares it.
  task automatic model_push(input bit io, input bit rd, input logic [15:0] addr,
                            input logic [7:0] data, input logic [NS-1:0] hit,
                            input int delay, input logic [31:0] rdata);
    int g;
    bit owned, tmo;
    int wait_cycles;
    logic [7:0] dout;
    g = lowest_idx(hit);
    owned = (g >= 0);
    tmo = owned && (delay >= TMO);
    wait_cycles = !owned ? 0 : (tmo ? TMO : delay + 1);
    dout = 8'h00;
    if (owned && rd) dout = tmo ? 8'hFF : rdata[8*g +: 8];
    exp_q.push_back(owned ? (32'd1 << g) : 32'd0);
    exp_q.push_back(32'(owned && rd));
    exp_q.push_back(32'(owned && !rd));
    exp_q.push_back(32'(wait_cycles));
    exp_q.push_back(32'(tmo));
    exp_q.push_back(32'(owned && rd));
    exp_q.push_back(32'(dout));
    exp_q.push_back((owned && rd) ? 32'(STAB - 1) : 32'd0);
    exp_q.push_back(32'(addr));
    exp_q.push_back(32'(data));
    exp_q.push_back(32'(io));
    exp_q.push_back(32'd0);
    exp_q.push_back(32'd1);
    exp_q.push_back(32'hFF);
    exp_q.push_back(32'd1);
  endtask

  // ---------------- drivers ----------------
  task automatic bus_idle();
    bus.SLTSL_n = 1'b1; bus.MERQ_n = 1'b1; bus.IORQ_n = 1'b1;
    bus.RD_n = 1'b1; bus.WR_n = 1'b1; bus.RFSH_n = 1'b1;
  endtask

  task automatic bus_start(input bit io, input bit rd);
    bus.RD_n = !rd;
    bus.WR_n = rd;
    if (io) bus.IORQ_n = 1'b0;
    else begin
      bus.SLTSL_n = 1'b0;
      bus.MERQ_n = 1'b0;
    end
  endtask

  task automatic run_txn(input bit io, input bit rd, input logic [15:0] addr,
                         input logic [7:0] data, input logic [NS-1:0] hit,
                         input int delay, input logic [31:0] rdata);
    int g, n, cyc, hold, post;
    int wait_low, rds, wrs, tos, bd_low, rel_hold;
    bit stb_seen, released;
    logic [NS-1:0] grant_or, distract;
    logic [7:0] dout_seen;
    g = lowest_idx(hit);
    model_push(io, rd, addr, data, hit, delay, rdata);
    distract = NS'($urandom_range(0, 15));
    if (g >= 0) distract[g] = 1'b0;
    {n, cyc, hold, post, wait_low, rds, wrs, tos, bd_low, rel_hold} = '0;
    stb_seen = 1'b0; released = 1'b0; grant_or = '0; dout_seen = 8'h00;

    @(negedge CLK);
    bus.ADDR = addr; bus.DIN = data; bus.slv_hit = hit;
    bus.slv_rdata = rdata; bus.slv_ready = distract;
    bus_start(io, rd);
    while (n < 80) begin
      @(negedge CLK);
      n++;
      if (bus.slv_rd_stb) rds++;
      if (bus.slv_wr_stb) wrs++;
      if (!bus.WAIT_n) wait_low++;
      if (bus.timeout_err) tos++;
      grant_or |= bus.slv_grant;
      if (!bus.BUSDIR_n) begin
        bd_low++;
        dout_seen = bus.DOUT;
      end
      if (released) begin
        if (!bus.BUSDIR_n) rel_hold++;
        post++;
        if (post == 8) break;
      end else begin
        if (!stb_seen && (bus.slv_rd_stb || bus.slv_wr_stb)) begin
          stb_seen = 1'b1;
          cyc = 0;
          // Late bus/claim changes must not disturb the latched cycle.
          bus.ADDR = 16'($urandom);
          bus.DIN = 8'($urandom);
          bus.slv_hit = NS'($urandom_range(0, 15));
        end else if (stb_seen) cyc++;
        if (stb_seen && cyc == delay && g >= 0) bus.slv_ready[g] = 1'b1;
        if (stb_seen && bus.WAIT_n) hold++;
        if (hold == 2 || (!stb_seen && n == 12)) begin
          bus_idle();
          released = 1'b1;
        end
      end
    end
    bus.slv_ready = '0;

    chk_q("grant", 32'(grant_or));
    chk_q("rd_stb_count", 32'(rds));
    chk_q("wr_stb_count", 32'(wrs));
    chk_q("wait_low_cycles", 32'(wait_low));
    chk_q("timeout_pulses", 32'(tos));
    chk_q("drove_bus", 32'(bd_low > 0));
    chk_q("dout_driven", 32'(dout_seen));
    chk_q("release_hold", 32'(rel_hold));
    chk_q("slv_addr", 32'(bus.slv_addr));
    chk_q("slv_wdata", 32'(bus.slv_wdata));
    chk_q("slv_io", 32'(bus.slv_io));
    chk_q("end_grant", 32'(bus.slv_grant));
    chk_q("end_busdir_n", 32'(bus.BUSDIR_n));
    chk_q("end_dout", 32'(bus.DOUT));
    chk_q("end_wait_n", 32'(bus.WAIT_n));
  endtask

  // Drive a non-qualifying pattern for len cycles; nothing may start.
  task automatic run_nostart(input string tag, input logic [5:0] pins, input int len);
    int stbs, wait_low, bd_low;
    logic [NS-1:0] grant_or;
    stbs = 0; wait_low = 0; bd_low = 0; grant_or = '0;
    @(negedge CLK);
    bus.slv_hit = 4'b0001;
    bus.slv_ready = '0;
    {bus.SLTSL_n, bus.MERQ_n, bus.IORQ_n, bus.RD_n, bus.WR_n, bus.RFSH_n} = pins;
    for (int i = 0; i < len + 8; i++) begin
      @(negedge CLK);
      if (i == len - 1) bus_idle();
      if (bus.slv_rd_stb || bus.slv_wr_stb) stbs++;
      if (!bus.WAIT_n) wait_low++;
      if (!bus.BUSDIR_n) bd_low++;
      grant_or |= bus.slv_grant;
    end
    chk({tag, "_strobes"}, 32'(stbs), 32'd0);
    chk({tag, "_wait_low"}, 32'(wait_low), 32'd0);
    chk({tag, "_busdir_low"}, 32'(bd_low), 32'd0);
    chk({tag, "_grant"}, 32'(grant_or), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    bit io, rd;
    logic [15:0] addr;

    bus_idle();
    bus.ADDR = 16'h0000; bus.DIN = 8'h00;
    bus.slv_hit = '0; bus.slv_rdata = '0; bus.slv_ready = '0;
    RESET_n = 1'b0;
    repeat (3) @(negedge CLK);

    chk("rst_grant", 32'(bus.slv_grant), 32'd0);
    chk("rst_rd_stb", 32'(bus.slv_rd_stb), 32'd0);
    chk("rst_wr_stb", 32'(bus.slv_wr_stb), 32'd0);
    chk("rst_addr", 32'(bus.slv_addr), 32'd0);
    chk("rst_wdata", 32'(bus.slv_wdata), 32'd0);
    chk("rst_io", 32'(bus.slv_io), 32'd0);
    chk("rst_dout", 32'(bus.DOUT), 32'hFF);
    chk("rst_busdir_n", 32'(bus.BUSDIR_n), 32'd1);
    chk("rst_wait_n", 32'(bus.WAIT_n), 32'd1);
    chk("rst_timeout", 32'(bus.timeout_err), 32'd0);
    RESET_n = 1'b1;
    repeat (2) @(negedge CLK);

    // Plan cases: slow read, zero-wait IO write, unclaimed read, timeout read.
    run_txn(1'b0, 1'b1, 16'h4000, 8'h00, 4'b0110, 3, 32'hC3D45AE1);
    run_txn(1'b1, 1'b0, 16'h007C, 8'h3C, 4'b1000, 0, 32'h01020304);
    run_txn(1'b0, 1'b1, 16'h8123, 8'h77, 4'b0000, 0, 32'hAABBCCDD);
    run_txn(1'b0, 1'b1, 16'h6000, 8'h11, 4'b0100, NEVER, 32'h12345678);
    run_txn(1'b0, 1'b0, 16'h5555, 8'hA5, 4'b0001, NEVER, 32'h0);

    // pins = {SLTSL_n, MERQ_n, IORQ_n, RD_n, WR_n, RFSH_n}
    run_nostart("merq_glitch", 6'b001011, 1);
    run_nostart("refresh_read", 6'b001010, 6);
    run_nostart("rd_wr_both", 6'b001001, 6);
    run_nostart("merq_iorq_both", 6'b000011, 6);

    // Reset in the middle of a wait-stated access.
    @(negedge CLK);
    bus.ADDR = 16'h4321; bus.slv_hit = 4'b0001; bus.slv_ready = '0;
    bus_start(1'b0, 1'b1);
    n = 0;
    while (n < 20 && !bus.slv_rd_stb) begin
      @(negedge CLK);
      n++;
    end
    @(negedge CLK);
    chk("pre_reset_wait_n", 32'(bus.WAIT_n), 32'd0);
    #1 RESET_n = 1'b0;
    #1;
    chk("async_rst_wait_n", 32'(bus.WAIT_n), 32'd1);
    chk("async_rst_busdir_n", 32'(bus.BUSDIR_n), 32'd1);
    chk("async_rst_grant", 32'(bus.slv_grant), 32'd0);
    chk("async_rst_strobes", 32'({bus.slv_rd_stb, bus.slv_wr_stb}), 32'd0);
    bus_idle();
    repeat (2) @(negedge CLK);
    RESET_n = 1'b1;
    run_txn(1'b0, 1'b1, 16'h4000, 8'h00, 4'b0010, 1, 32'h00009900);

    // Randomized cycles.
    for (int t = 0; t < 30; t++) begin
      io = 1'($urandom_range(0, 1));
      rd = 1'($urandom_range(0, 1));
      addr = io ? {8'h00, 8'($urandom)} : 16'($urandom);
      run_txn(io, rd, addr, 8'($urandom), NS'($urandom_range(0, 15)),
              $urandom_range(0, 10), $urandom);
    end

    if (exp_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL scoreboard_leftover observed=%0d expected=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
